// File: rtl/shot_capture_nch.sv
// shot_capture_nch: N-channel shot capture with threshold trigger, windowed peak hold and freeze override.
// Build option: define SHOT_AUTO_REARM_EN for a timed return from HOLD to ARMED.
//
// state   | meaning
// IDLE    | live samples shown, waiting for arm
// ARMED   | live samples shown, waiting for any channel >= THRESH
// CAPTURE | peaks shown and updated until the window counter reaches zero
// HOLD    | captured peaks shown static, waiting for arm/clear (or dwell expiry)
module shot_capture_nch #(
    parameter int           NCH          = 2,
    parameter int           W            = 16,
    parameter logic [W-1:0] THRESH       = 16'd512,
    parameter int           WINDOW       = 4000,
    parameter int           REARM_CYCLES = 400000,
    localparam int          TW           = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   smp_valid,
    input  logic [NCH*W-1:0] smp_data,
    input  logic             arm,
    input  logic             clear,
    input  logic             freeze,
    output logic [NCH*W-1:0] disp_data,
    output logic [TW-1:0]    trig_ch,
    output logic             shot_done,
    output logic [1:0]       state
);

    localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    if (NCH < 1 || NCH > 8 || W < 1 || WINDOW < 1 || REARM_CYCLES < 1) begin : g_bad_params
        $error("shot_capture_nch: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t         state_q;
    state_t         state_d;

    logic [W-1:0]   smp  [NCH];
    logic [W-1:0]   live [NCH];
    logic [W-1:0]   peak [NCH];
    logic [W-1:0]   frz  [NCH];
    logic [W-1:0]   src  [NCH];

    logic [CW-1:0]  win_q;
    logic [TW-1:0]  trig_q;
    logic           done_q;
    logic           frz_prev;

    logic           any_hit;
    logic [TW-1:0]  hit_ch;
    logic           trig_fire;
    logic           win_end;
    logic           fold_en;
    logic           rearm_due;

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            smp[k] = smp_data[k*W +: W];
        end
    end

    // Descending scan so the lowest triggering channel wins.
    always_comb begin
        any_hit = 1'b0;
        hit_ch  = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (smp_valid[k] && smp[k] >= THRESH) begin
                any_hit = 1'b1;
                hit_ch  = TW'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        trig_fire = 1'b0;
        win_end   = 1'b0;
        fold_en   = 1'b0;
        if (clear) begin
            state_d = IDLE;
        end else if (arm && (state_q == IDLE || state_q == HOLD)) begin
            state_d = ARMED;
        end else begin
            case (state_q)
                ARMED: begin
                    if (any_hit) begin
                        state_d   = CAPTURE;
                        trig_fire = 1'b1;
                    end
                end
                CAPTURE: begin
                    if (win_q == '0) begin
                        state_d = HOLD;
                        win_end = 1'b1;
                    end else begin
                        fold_en = 1'b1;
                    end
                end
                HOLD: begin
                    if (rearm_due) begin
                        state_d = ARMED;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            src[k] = (state_q == IDLE || state_q == ARMED) ? live[k] : peak[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                live[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (smp_valid[k]) begin
                    live[k] <= smp[k];
                end
            end
        end
    end

    // On trigger, channels without a same-cycle sample start from their live value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                peak[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (clear) begin
                    peak[k] <= '0;
                end else if (trig_fire) begin
                    peak[k] <= smp_valid[k] ? smp[k] : live[k];
                end else if (fold_en && smp_valid[k] && smp[k] > peak[k]) begin
                    peak[k] <= smp[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q  <= '0;
            trig_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= win_end;
            if (clear) begin
                win_q <= '0;
            end else if (trig_fire) begin
                win_q <= CW'(WINDOW - 1);
            end else if (fold_en) begin
                win_q <= win_q - CW'(1);
            end
            if (trig_fire) begin
                trig_q <= hit_ch;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frz_prev <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                frz[k] <= '0;
            end
        end else begin
            frz_prev <= freeze;
            for (int k = 0; k < NCH; k++) begin
                if (freeze && !frz_prev) begin
                    frz[k] <= src[k];
                end
            end
        end
    end

`ifdef SHOT_AUTO_REARM_EN
    localparam int DW = (REARM_CYCLES > 1) ? $clog2(REARM_CYCLES) : 1;

    logic [DW-1:0] dwell_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q <= '0;
        end else if (clear) begin
            dwell_q <= '0;
        end else if (win_end) begin
            dwell_q <= DW'(REARM_CYCLES - 1);
        end else if (state_q == HOLD && dwell_q != '0) begin
            dwell_q <= dwell_q - DW'(1);
        end
    end

    assign rearm_due = (dwell_q == '0);
`else
    assign rearm_due = 1'b0;
`endif

    // Select uses the registered freeze copy so the display only ever switches on a clock edge.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            disp_data[k*W +: W] = frz_prev ? frz[k] : src[k];
        end
    end

    assign trig_ch   = trig_q;
    assign shot_done = done_q;
    assign state     = state_q;

endmodule

// File: tb/tb_shot_capture_nch.sv
// Bench for shot_capture_nch: reset checks, a hand-derived vector table, multi-cycle corner
// sequences and a randomized run against a timestamp-based reference model.
module tb_shot_capture_nch;

    localparam int NCH    = 2;
    localparam int W      = 16;
    localparam int WINDOW = 8;
    localparam int REARM  = 5;
    localparam int TH     = 512;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NCH-1:0]   smp_valid = '0;
    logic [NCH*W-1:0] smp_data = '0;
    logic             arm = 1'b0;
    logic             clear = 1'b0;
    logic             freeze = 1'b0;
    logic [NCH*W-1:0] disp_data;
    logic [0:0]       trig_ch;
    logic             shot_done;
    logic [1:0]       state;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    shot_capture_nch #(
        .NCH(NCH), .W(W), .THRESH(16'd512), .WINDOW(WINDOW), .REARM_CYCLES(REARM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .smp_valid(smp_valid), .smp_data(smp_data),
        .arm(arm), .clear(clear), .freeze(freeze), .disp_data(disp_data),
        .trig_ch(trig_ch), .shot_done(shot_done), .state(state)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        smp_valid = '0;
        smp_data  = '0;
        arm       = 1'b0;
        clear     = 1'b0;
    endtask

    typedef struct packed {
        logic [1:0]  vld;
        logic [15:0] x;
        logic [15:0] y;
        logic        a;
        logic        c;
        logic [1:0]  st;
        logic [15:0] ex;
        logic [15:0] ey;
        logic        dn;
        logic        tr;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] vld, input int x, input int y, input logic a,
                                input logic c, input int st, input int ex, input int ey,
                                input logic dn, input logic tr);
        vec_t v;
        v.vld = vld; v.x = 16'(x); v.y = 16'(y); v.a = a; v.c = c;
        v.st = 2'(st); v.ex = 16'(ex); v.ey = 16'(ey); v.dn = dn; v.tr = tr;
        return v;
    endfunction

    localparam int NV = 20;
    vec_t tbl [NV];

    // Reference model: window and dwell expressed as timestamps on a running edge count.
    int           m_state;
    int           m_trig;
    logic         m_done;
    logic         m_frzq;
    logic [W-1:0] m_live [NCH];
    logic [W-1:0] m_peak [NCH];
    logic [W-1:0] m_frz  [NCH];
    int           cyc;
    int           t_trig;
    int           t_hold;

    task automatic model_reset();
        m_state = 0; m_trig = 0; m_done = 1'b0; m_frzq = 1'b0;
        cyc = 0; t_trig = 0; t_hold = 0;
        for (int k = 0; k < NCH; k++) begin
            m_live[k] = '0; m_peak[k] = '0; m_frz[k] = '0;
        end
    endtask

    task automatic model_edge(input logic [NCH-1:0] v, input logic [NCH*W-1:0] d,
                              input logic a, input logic c, input logic f);
        logic [W-1:0] shown [NCH];
        logic [W-1:0] prev_live [NCH];
        int first;
        cyc++;
        for (int k = 0; k < NCH; k++) begin
            shown[k]     = (m_state < 2) ? m_live[k] : m_peak[k];
            prev_live[k] = m_live[k];
            if (v[k]) m_live[k] = d[k*W +: W];
        end
        if (f && !m_frzq) begin
            for (int k = 0; k < NCH; k++) m_frz[k] = shown[k];
        end
        m_frzq = f;
        m_done = 1'b0;
        if (c) begin
            m_state = 0;
            for (int k = 0; k < NCH; k++) m_peak[k] = '0;
        end else if (a && (m_state == 0 || m_state == 3)) begin
            m_state = 1;
        end else if (m_state == 1) begin
            first = -1;
            for (int k = 0; k < NCH; k++) begin
                if (first < 0 && v[k] && int'(d[k*W +: W]) >= TH) first = k;
            end
            if (first >= 0) begin
                m_state = 2; m_trig = first; t_trig = cyc;
                for (int k = 0; k < NCH; k++) m_peak[k] = v[k] ? d[k*W +: W] : prev_live[k];
            end
        end else if (m_state == 2) begin
            if (cyc == t_trig + WINDOW) begin
                m_state = 3; m_done = 1'b1; t_hold = cyc;
            end else begin
                for (int k = 0; k < NCH; k++) begin
                    if (v[k] && d[k*W +: W] > m_peak[k]) m_peak[k] = d[k*W +: W];
                end
            end
        end
`ifdef SHOT_AUTO_REARM_EN
        else if (m_state == 3 && cyc == t_hold + REARM) begin
            m_state = 1;
        end
`endif
    endtask

    function automatic logic [NCH*W-1:0] model_disp();
        logic [NCH*W-1:0] e;
        for (int k = 0; k < NCH; k++) begin
            e[k*W +: W] = m_frzq ? m_frz[k] : ((m_state < 2) ? m_live[k] : m_peak[k]);
        end
        return e;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic             seen;
        int               n;
        logic [NCH-1:0]   rv;
        logic [NCH*W-1:0] rd;

        tbl[0]  = mk(2'b11, 100,  200,  0, 0, 0, 100,  200,  0, 0);
        tbl[1]  = mk(2'b00, 0,    0,    1, 0, 1, 100,  200,  0, 0);
        tbl[2]  = mk(2'b10, 0,    600,  0, 0, 2, 100,  600,  0, 1);
        tbl[3]  = mk(2'b00, 0,    0,    0, 0, 2, 100,  600,  0, 1);
        tbl[4]  = mk(2'b01, 50,   0,    0, 0, 2, 100,  600,  0, 1);
        tbl[5]  = mk(2'b10, 0,    900,  0, 0, 2, 100,  900,  0, 1);
        tbl[6]  = mk(2'b01, 300,  0,    0, 0, 2, 300,  900,  0, 1);
        tbl[7]  = mk(2'b00, 0,    0,    0, 0, 2, 300,  900,  0, 1);
        tbl[8]  = mk(2'b10, 0,    50,   0, 0, 2, 300,  900,  0, 1);
        tbl[9]  = mk(2'b01, 400,  0,    0, 0, 2, 400,  900,  0, 1);
        tbl[10] = mk(2'b11, 1000, 1000, 0, 0, 3, 400,  900,  1, 1);
        tbl[11] = mk(2'b00, 0,    0,    0, 0, 3, 400,  900,  0, 1);
        tbl[12] = mk(2'b00, 0,    0,    1, 0, 1, 1000, 1000, 0, 1);
        tbl[13] = mk(2'b11, 600,  700,  0, 0, 2, 600,  700,  0, 0);
        tbl[14] = mk(2'b10, 0,    50,   0, 0, 2, 600,  700,  0, 0);
        tbl[15] = mk(2'b00, 0,    0,    0, 1, 0, 600,  50,   0, 0);
        tbl[16] = mk(2'b00, 0,    0,    1, 0, 1, 600,  50,   0, 0);
        tbl[17] = mk(2'b10, 0,    511,  0, 0, 1, 600,  511,  0, 0);
        tbl[18] = mk(2'b10, 0,    512,  0, 0, 2, 600,  512,  0, 1);
        tbl[19] = mk(2'b00, 0,    0,    0, 1, 0, 600,  512,  0, 1);

        #23;
        chk("reset_disp", disp_data, 0);
        chk("reset_state", state, 0);
        chk("reset_done", shot_done, 0);
        chk("reset_trig", trig_ch, 0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            smp_valid = tbl[i].vld;
            smp_data  = {tbl[i].y, tbl[i].x};
            arm       = tbl[i].a;
            clear     = tbl[i].c;
            tick();
            chk($sformatf("vec%0d_state", i), state, tbl[i].st);
            chk($sformatf("vec%0d_disp", i), disp_data, {tbl[i].ey, tbl[i].ex});
            chk($sformatf("vec%0d_done", i), shot_done, tbl[i].dn);
            chk($sformatf("vec%0d_trig", i), trig_ch, tbl[i].tr);
        end
        idle_inputs();

        // Clear in the middle of a window: no shot_done for it, live values shown.
        arm = 1'b1; tick(); idle_inputs();
        smp_valid = 2'b10; smp_data = {16'd700, 16'd0}; tick(); idle_inputs();
        chk("midclr_capture", state, 2);
        repeat (3) tick();
        clear = 1'b1; tick(); idle_inputs();
        chk("midclr_state", state, 0);
        chk("midclr_disp", disp_data, {16'd700, 16'd600});
        seen = 1'b0;
        repeat (12) begin
            tick();
            seen |= shot_done;
        end
        chk("midclr_no_done", seen, 0);

        // Freeze captured in IDLE persists across a trigger, then the peak appears.
        smp_valid = 2'b01; smp_data = {16'd0, 16'd300}; tick(); idle_inputs();
        freeze = 1'b1; tick();
        chk("frz_hold_x", disp_data[15:0], 300);
        arm = 1'b1; tick(); idle_inputs();
        smp_valid = 2'b11; smp_data = {16'd800, 16'd999}; tick(); idle_inputs();
        chk("frz_trig_state", state, 2);
        chk("frz_trig_disp", disp_data, {16'd700, 16'd300});
        repeat (2) tick();
        chk("frz_still_x", disp_data[15:0], 300);
        freeze = 1'b0; tick();
        chk("frz_release_disp", disp_data, {16'd800, 16'd999});

        // HOLD dwell behaviour.
        for (int i = 0; i < 20 && state != 2'd3; i++) tick();
        chk("hold_reached", state, 3);
`ifdef SHOT_AUTO_REARM_EN
        n = 0;
        for (int i = 0; i < 20 && state != 2'd1; i++) begin
            tick();
            n++;
        end
        chk("rearm_cycles", n, REARM);
        chk("rearm_state", state, 1);
`else
        n = 0;
        repeat (20) tick();
        chk("hold_persists", state, 3);
`endif
        clear = 1'b1; tick(); idle_inputs();

        // Asynchronous reset acts mid-cycle.
        smp_valid = 2'b11; smp_data = {16'd6, 16'd5}; tick(); idle_inputs();
        arm = 1'b1; tick(); idle_inputs();
        chk("pre_async_disp", disp_data, {16'd6, 16'd5});
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_disp", disp_data, 0);
        chk("async_state", state, 0);
        #2;
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 2500; i++) begin
            for (int k = 0; k < NCH; k++) begin
                rv[k] = ($urandom_range(0, 3) != 0);
                rd[k*W +: W] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(TH, 1023))
                                                           : 16'($urandom_range(0, TH - 1));
            end
            smp_valid = rv;
            smp_data  = rd;
            arm       = ($urandom_range(0, 5) == 0);
            clear     = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 15) == 0) freeze = ~freeze;
            tick();
            model_edge(rv, rd, arm, clear, freeze);
            chk($sformatf("rand%0d_state", i), state, m_state);
            chk($sformatf("rand%0d_disp", i), disp_data, model_disp());
            chk($sformatf("rand%0d_done", i), shot_done, m_done);
            chk($sformatf("rand%0d_trig", i), trig_ch, m_trig);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
